// File: rtl/key_cmd_pkg.sv
// Shared types and default timing for the front-panel key decoder.
package key_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HOLD_UP,
      REP_UP,
      HOLD_DN,
      REP_DN,
      LOCK
   } state_t;

   localparam int unsigned TICK_DIV_DEF   = 50000;
   localparam int unsigned DEB_TICKS_DEF  = 10;
   localparam int unsigned HOLD_TICKS_DEF = 500;
   localparam int unsigned REP_TICKS_DEF  = 100;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_cmd_deb.sv
// One key: two-flop synchronizer followed by a tick-sampled debounce counter.
module key_deb
   import key_cmd_pkg::*;
#(
   parameter int unsigned DEB_TICKS = DEB_TICKS_DEF
) (
   input  logic CLK,
   input  logic RSTX,
   input  logic i_tick,
   input  logic i_raw,
   output logic o_stable
);

   localparam int unsigned CW = $clog2(DEB_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_stable;

   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         r_sync   <= '0;
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_raw};
         if (i_tick) begin
            if (r_sync[1] != r_stable) begin
               // The tick that completes the run flips the level and restarts the count.
               if (r_cnt == CNT_LAST) begin
                  r_stable <= ~r_stable;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end else begin
               r_cnt <= '0;
            end
         end
      end
   end

   assign o_stable = r_stable;

endmodule

// File: rtl/key_cmd.sv
// UP/DN key decoder: single-step pulse on press, decade-step auto-repeat on hold.
module key_cmd
   import key_cmd_pkg::*;
#(
   parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
   parameter int unsigned DEB_TICKS  = DEB_TICKS_DEF,
   parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF,
   parameter int unsigned REP_TICKS  = REP_TICKS_DEF
) (
   input  logic       RSTX,
   input  logic       CLK,
   input  logic       KEY_UP,
   input  logic       KEY_DN,
   output logic       ADD1,
   output logic       ADD10,
   output logic       SUB1,
   output logic       SUB10,
   output logic [1:0] KEYS
);

   localparam int unsigned PW   = $clog2(TICK_DIV);
   localparam int unsigned TMAX = max2(max2(HOLD_TICKS, REP_TICKS), 2);
   localparam int unsigned TW   = $clog2(TMAX);

   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRE_ONE   = PW'(1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);
   localparam logic [TW-1:0] REP_LAST  = TW'(REP_TICKS - 1);
   localparam logic [TW-1:0] TMR_ONE   = TW'(1);

   logic [PW-1:0] r_pre;
   logic          w_tick;
   logic          w_up;
   logic          w_dn;
   logic [TW-1:0] w_limit;
   logic          w_fire;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic          r_add1;
   logic          r_add10;
   logic          r_sub1;
   logic          r_sub10;

   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         r_pre <= '0;
      end else if (r_pre == PRE_LAST) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + PRE_ONE;
      end
   end

   assign w_tick = (r_pre == PRE_LAST);

   key_deb #(.DEB_TICKS(DEB_TICKS)) u_deb_up (
      .CLK      (CLK),
      .RSTX     (RSTX),
      .i_tick   (w_tick),
      .i_raw    (KEY_UP),
      .o_stable (w_up)
   );

   key_deb #(.DEB_TICKS(DEB_TICKS)) u_deb_dn (
      .CLK      (CLK),
      .RSTX     (RSTX),
      .i_tick   (w_tick),
      .i_raw    (KEY_DN),
      .o_stable (w_dn)
   );

   // Hold and repeat states share one timer; only the terminal count differs.
   assign w_limit = (r_state == HOLD_UP || r_state == HOLD_DN) ? HOLD_LAST : REP_LAST;
   assign w_fire  = w_tick && (r_timer == w_limit);

   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         r_state <= IDLE;
         r_timer <= '0;
         r_add1  <= 1'b0;
         r_add10 <= 1'b0;
         r_sub1  <= 1'b0;
         r_sub10 <= 1'b0;
      end else begin
         r_add1  <= 1'b0;
         r_add10 <= 1'b0;
         r_sub1  <= 1'b0;
         r_sub10 <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_timer <= '0;
               if (w_up && w_dn) begin
                  r_state <= LOCK;
               end else if (w_up) begin
                  r_add1  <= 1'b1;
                  r_state <= HOLD_UP;
               end else if (w_dn) begin
                  r_sub1  <= 1'b1;
                  r_state <= HOLD_DN;
               end
            end
            HOLD_UP, REP_UP: begin
               if (!w_up) begin
                  r_state <= IDLE;
                  r_timer <= '0;
               end else if (w_dn) begin
                  r_state <= LOCK;
                  r_timer <= '0;
               end else if (w_fire) begin
                  r_add10 <= 1'b1;
                  r_state <= REP_UP;
                  r_timer <= '0;
               end else if (w_tick) begin
                  r_timer <= r_timer + TMR_ONE;
               end
            end
            HOLD_DN, REP_DN: begin
               if (!w_dn) begin
                  r_state <= IDLE;
                  r_timer <= '0;
               end else if (w_up) begin
                  r_state <= LOCK;
                  r_timer <= '0;
               end else if (w_fire) begin
                  r_sub10 <= 1'b1;
                  r_state <= REP_DN;
                  r_timer <= '0;
               end else if (w_tick) begin
                  r_timer <= r_timer + TMR_ONE;
               end
            end
            LOCK: begin
               r_timer <= '0;
               if (!w_up && !w_dn) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_timer <= '0;
            end
         endcase
      end
   end

   assign ADD1  = r_add1;
   assign ADD10 = r_add10;
   assign SUB1  = r_sub1;
   assign SUB10 = r_sub10;
   assign KEYS  = {w_dn, w_up};

endmodule
